// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared types and constants for the pipeline hazard controller.
//   - REG_AW       : register address width of the MIPS register file
//   - stage_info_t : EX-stage shadow of destination/control info
//   - mem_info_t   : MEM-stage shadow (only what forwarding needs)
//   - hz_state_t   : controller FSM states
package hazard_pkg;

  localparam int REG_AW = 5;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              regwr;
    logic              load;
    logic              is_jr;
  } stage_info_t;

  // By the time an instruction reaches MEM its load/jr hazards have been
  // resolved, so only the write-back identity is kept.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              regwr;
  } mem_info_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hz_state_t;

  function automatic mem_info_t to_mem_info(stage_info_t s);
    mem_info_t m;
    m.valid = s.valid;
    m.dst   = s.dst;
    m.regwr = s.regwr;
    return m;
  endfunction

endpackage

// File: rtl/hazard_unit_fwd_compare.sv
// fwd_compare
//   Compares one ID-stage source operand against the EX and MEM shadow
//   entries and produces that operand's forwarding selects.
//   Ports:
//     uses     in  operand is actually read by the ID instruction
//     src      in  operand register number
//     ex_wr    in  EX entry is valid and writes the register file
//     ex_dst   in  EX entry destination register
//     ex_load  in  EX entry is a load (data not available yet)
//     mem_wr   in  MEM entry is valid and writes the register file
//     mem_dst  in  MEM entry destination register
//     match_ex out operand depends on the EX entry (used for load-use)
//     ex_fwd   out select ALU result
//     mem_fwd  out select MEM write-back data
module fwd_compare
  import hazard_pkg::*;
(
  input  logic              uses,
  input  logic [REG_AW-1:0] src,
  input  logic              ex_wr,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              ex_load,
  input  logic              mem_wr,
  input  logic [REG_AW-1:0] mem_dst,
  output logic              match_ex,
  output logic              ex_fwd,
  output logic              mem_fwd
);

  logic src_nz;

  // $0 is hardwired to zero, so a "write" to it must never be forwarded.
  assign src_nz   = |src;
  assign match_ex = uses & ex_wr & (ex_dst == src) & src_nz;
  assign ex_fwd   = match_ex & ~ex_load;
  // The younger EX producer always wins over MEM.
  assign mem_fwd  = ~match_ex & mem_wr & (mem_dst == src) & src_nz;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit
//   Hazard/forwarding controller for the 5-stage 32-bit MIPS pipeline.
//   Keeps shadow copies of EX and MEM destination info, drives the operand
//   forwarding selects, inserts a one-cycle bubble on load-use, flushes
//   wrong-path fetches after jr, and freezes everything while data memory
//   is not ready.
//
//   Optional build macro HAZARD_PERF_EN adds saturating performance counters
//   (stall_cnt, flush_cnt, freeze_cnt).
//
//   Ports:
//     clk, rst                 clock; asynchronous active-low reset
//     id_valid .. id_is_jr     decoded ID-stage instruction info
//     dmem_ready               data memory can complete this cycle
//     ex/mem_forward_a/b       operand forwarding selects
//     stall_if, stall_id       hold PC / IF-ID register
//     bubble_ex                load NOP controls into ID/EX
//     flush_id                 load NOP into IF/ID
//     freeze                   hold all pipeline registers
//     stall/flush/freeze_cnt   performance counters (HAZARD_PERF_EN only)
//
//   State | meaning
//   ------+-----------------------------------------------------------
//   RUN   | normal issue; load-use stalls allowed
//   FLUSH | jr resolved in EX; squash IF/ID and ID/EX for cnt+1 cycles
//
//   REG_AW must equal hazard_pkg::REG_AW (the shadow types are sized by it).
module hazard_unit #(
  parameter int REG_AW          = 5,
  parameter int JR_FLUSH_CYCLES = 1,
  parameter int PERF_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_regwr,
  input  logic              id_load,
  input  logic              id_is_jr,
  input  logic              dmem_ready,
  output logic              ex_forward_a,
  output logic              mem_forward_a,
  output logic              ex_forward_b,
  output logic              mem_forward_b,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              flush_id,
  output logic              freeze
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt,
  output logic [PERF_W-1:0] freeze_cnt
`endif
);

  import hazard_pkg::*;

  localparam int             CNT_W      = 2;
  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(JR_FLUSH_CYCLES - 1);

  if (PERF_W < 1 || JR_FLUSH_CYCLES < 1 || JR_FLUSH_CYCLES > 3) begin : g_param_check
    $error("hazard_unit: JR_FLUSH_CYCLES must be 1..3 and PERF_W >= 1");
  end

  stage_info_t      ex_q, ex_d;
  mem_info_t        mem_q;
  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic match_ex_a, match_ex_b;
  logic fwd_ex_a, fwd_mem_a, fwd_ex_b, fwd_mem_b;
  logic ex_wr, mem_wr;
  logic lu, jr_in_ex;

  assign ex_wr  = ex_q.valid & ex_q.regwr;
  assign mem_wr = mem_q.valid & mem_q.regwr;

  fwd_compare u_fwd_a (
    .uses     (id_uses_rs),
    .src      (id_rs),
    .ex_wr    (ex_wr),
    .ex_dst   (ex_q.dst),
    .ex_load  (ex_q.load),
    .mem_wr   (mem_wr),
    .mem_dst  (mem_q.dst),
    .match_ex (match_ex_a),
    .ex_fwd   (fwd_ex_a),
    .mem_fwd  (fwd_mem_a)
  );

  fwd_compare u_fwd_b (
    .uses     (id_uses_rt),
    .src      (id_rt),
    .ex_wr    (ex_wr),
    .ex_dst   (ex_q.dst),
    .ex_load  (ex_q.load),
    .mem_wr   (mem_wr),
    .mem_dst  (mem_q.dst),
    .match_ex (match_ex_b),
    .ex_fwd   (fwd_ex_b),
    .mem_fwd  (fwd_mem_b)
  );

  assign freeze   = ~dmem_ready;
  assign lu       = id_valid & (match_ex_a | match_ex_b) & ex_q.load;
  assign jr_in_ex = ex_q.valid & ex_q.is_jr;

  // Outputs. Under freeze every register holds, so stall/bubble/flush are
  // meaningless and kept low; forwarding stays live because the datapath
  // still computes operands from the held values.
  always_comb begin
    ex_forward_a  = fwd_ex_a;
    mem_forward_a = fwd_mem_a;
    ex_forward_b  = fwd_ex_b;
    mem_forward_b = fwd_mem_b;
    stall_if      = 1'b0;
    stall_id      = 1'b0;
    bubble_ex     = 1'b0;
    flush_id      = 1'b0;
    if (!freeze) begin
      if (state_q == FLUSH) begin
        // Wrong-path instructions: nothing they read matters.
        flush_id      = 1'b1;
        bubble_ex     = 1'b1;
        ex_forward_a  = 1'b0;
        mem_forward_a = 1'b0;
        ex_forward_b  = 1'b0;
        mem_forward_b = 1'b0;
      end else if (lu) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!freeze) begin
      unique case (state_q)
        RUN: begin
          if (jr_in_ex) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_INIT;
          end
        end
        FLUSH: begin
          if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    ex_d       = '0;
    ex_d.valid = id_valid & ~bubble_ex;
    ex_d.dst   = id_dst;
    ex_d.regwr = id_regwr;
    ex_d.load  = id_load;
    ex_d.is_jr = id_is_jr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      state_q <= RUN;
      cnt_q   <= '0;
    end else if (!freeze) begin
      ex_q    <= ex_d;
      mem_q   <= to_mem_info(ex_q);
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  // Counters count effective events, i.e. what actually reached the outputs
  // after priority resolution; they keep counting while frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (stall_if && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + PERF_W'(1);
      end
      if (flush_id && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + PERF_W'(1);
      end
      if (freeze && (freeze_cnt != '1)) begin
        freeze_cnt <= freeze_cnt + PERF_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances share stimulus, one with a 1-cycle
// jr flush and one with a 2-cycle flush. Expected output vectors are queued
// as each cycle is driven and popped when the outputs are sampled.
// Output vector order: {ex_fa, mem_fa, ex_fb, mem_fb, stall_if, stall_id,
// bubble_ex, flush_id, freeze}.
module tb_hazard_unit;

  localparam logic [8:0] NONE  = 9'b0000_00000;
  localparam logic [8:0] EFA   = 9'b1000_00000;
  localparam logic [8:0] MFA   = 9'b0100_00000;
  localparam logic [8:0] EFB   = 9'b0010_00000;
  localparam logic [8:0] MFB   = 9'b0001_00000;
  localparam logic [8:0] STALL = 9'b0000_11100;
  localparam logic [8:0] FLSH  = 9'b0000_00110;
  localparam logic [8:0] FRZ   = 9'b0000_00001;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dst;
    logic       wr;
    logic       ld;
    logic       jr;
    logic       rdy;
    logic [8:0] e1;
    logic [8:0] e2;
  } stim_t;

  typedef struct packed {
    logic [8:0] e1;
    logic [8:0] e2;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       id_uses_rs = 1'b0;
  logic       id_uses_rt = 1'b0;
  logic [4:0] id_dst = '0;
  logic       id_regwr = 1'b0;
  logic       id_load = 1'b0;
  logic       id_is_jr = 1'b0;
  logic       dmem_ready = 1'b1;

  logic efa1, mfa1, efb1, mfb1, sif1, sid1, bub1, fl1, frz1;
  logic efa2, mfa2, efb2, mfb2, sif2, sid2, bub2, fl2, frz2;
  logic [8:0] out1, out2;
`ifdef HAZARD_PERF_EN
  logic [15:0] sc1, fc1, zc1, sc2, fc2, zc2;
`endif

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  assign out1 = {efa1, mfa1, efb1, mfb1, sif1, sid1, bub1, fl1, frz1};
  assign out2 = {efa2, mfa2, efb2, mfb2, sif2, sid2, bub2, fl2, frz2};

  hazard_unit #(.REG_AW(5), .JR_FLUSH_CYCLES(1), .PERF_W(16)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_regwr(id_regwr), .id_load(id_load), .id_is_jr(id_is_jr),
    .dmem_ready(dmem_ready),
    .ex_forward_a(efa1), .mem_forward_a(mfa1), .ex_forward_b(efb1),
    .mem_forward_b(mfb1), .stall_if(sif1), .stall_id(sid1),
    .bubble_ex(bub1), .flush_id(fl1), .freeze(frz1)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(sc1), .flush_cnt(fc1), .freeze_cnt(zc1)
`endif
  );

  hazard_unit #(.REG_AW(5), .JR_FLUSH_CYCLES(2), .PERF_W(16)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_regwr(id_regwr), .id_load(id_load), .id_is_jr(id_is_jr),
    .dmem_ready(dmem_ready),
    .ex_forward_a(efa2), .mem_forward_a(mfa2), .ex_forward_b(efb2),
    .mem_forward_b(mfb2), .stall_if(sif2), .stall_id(sid2),
    .bubble_ex(bub2), .flush_id(fl2), .freeze(frz2)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(sc2), .flush_cnt(fc2), .freeze_cnt(zc2)
`endif
  );

  function automatic stim_t mk(logic v, logic [4:0] rs, logic [4:0] rt,
                               logic urs, logic urt, logic [4:0] dst,
                               logic wr, logic ld, logic jr, logic rdy,
                               logic [8:0] e1, logic [8:0] e2);
    stim_t s;
    s.v = v; s.rs = rs; s.rt = rt; s.urs = urs; s.urt = urt; s.dst = dst;
    s.wr = wr; s.ld = ld; s.jr = jr; s.rdy = rdy; s.e1 = e1; s.e2 = e2;
    return s;
  endfunction

  // Drive one cycle of ID-stage inputs and queue the expected outputs.
  task automatic apply(input stim_t s);
    exp_t e;
    id_valid   = s.v;
    id_rs      = s.rs;
    id_rt      = s.rt;
    id_uses_rs = s.urs;
    id_uses_rt = s.urt;
    id_dst     = s.dst;
    id_regwr   = s.wr;
    id_load    = s.ld;
    id_is_jr   = s.jr;
    dmem_ready = s.rdy;
    e.e1 = s.e1;
    e.e2 = s.e2;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_dst = 0; id_regwr = 0; id_load = 0; id_is_jr = 0; dmem_ready = 1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    exp_t e;
    apply(mk(1, 5'd3, 5'd4, 1, 1, 5'd3, 1, 1, 1, 1, NONE, NONE));
    repeat (2) @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (out1 !== e.e1) begin errors++; $display("FAIL reset_hold dut1: got %b expected %b", out1, e.e1); end
    checks++;
    if (out2 !== e.e2) begin errors++; $display("FAIL reset_hold dut2: got %b expected %b", out2, e.e2); end
    @(posedge clk); #1;
    rst = 1'b1;
    apply(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, NONE, NONE));
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (out1 !== e.e1) begin errors++; $display("FAIL reset_release dut1: got %b expected %b", out1, e.e1); end
    checks++;
    if (out2 !== e.e2) begin errors++; $display("FAIL reset_release dut2: got %b expected %b", out2, e.e2); end
    @(posedge clk); #1;
  endtask

  // add $3 ; read $3 (EX fwd) ; read $3 and $8 (MEM fwd A, EX fwd B)
  task automatic test_ex_forward;
    stim_t t[$];
    exp_t  e;
    idle(2);
    t.push_back(mk(1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0, 1, NONE, NONE));
    t.push_back(mk(1, 5'd3, 5'd0, 1, 0, 5'd8, 1, 0, 0, 1, EFA, EFA));
    t.push_back(mk(1, 5'd3, 5'd8, 1, 1, 5'd0, 0, 0, 0, 1, MFA | EFB, MFA | EFB));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (out1 !== e.e1) begin errors++; $display("FAIL ex_forward[%0d] dut1: got %b expected %b", i, out1, e.e1); end
      checks++;
      if (out2 !== e.e2) begin errors++; $display("FAIL ex_forward[%0d] dut2: got %b expected %b", i, out2, e.e2); end
      @(posedge clk); #1;
    end
  endtask

  // Writers (and a load) of $0 in EX/MEM must never forward or stall.
  task automatic test_zero_reg;
    stim_t t[$];
    exp_t  e;
    idle(2);
    t.push_back(mk(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 1, NONE, NONE));
    t.push_back(mk(1, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 1, NONE, NONE));
    t.push_back(mk(1, 5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 0, 1, NONE, NONE));
    t.push_back(mk(1, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0, 1, NONE, NONE));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (out1 !== e.e1) begin errors++; $display("FAIL zero_reg[%0d] dut1: got %b expected %b", i, out1, e.e1); end
      checks++;
      if (out2 !== e.e2) begin errors++; $display("FAIL zero_reg[%0d] dut2: got %b expected %b", i, out2, e.e2); end
      @(posedge clk); #1;
    end
  endtask

  // $7 written by both EX and MEM: EX wins on both operands.
  task automatic test_priority;
    stim_t t[$];
    exp_t  e;
    idle(2);
    t.push_back(mk(1, 5'd0, 5'd0, 0, 0, 5'd7, 1, 0, 0, 1, NONE, NONE));
    t.push_back(mk(1, 5'd0, 5'd0, 0, 0, 5'd7, 1, 0, 0, 1, NONE, NONE));
    t.push_back(mk(1, 5'd7, 5'd7, 1, 1, 5'd0, 0, 0, 0, 1, EFA | EFB, EFA | EFB));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (out1 !== e.e1) begin errors++; $display("FAIL priority[%0d] dut1: got %b expected %b", i, out1, e.e1); end
      checks++;
      if (out2 !== e.e2) begin errors++; $display("FAIL priority[%0d] dut2: got %b expected %b", i, out2, e.e2); end
      @(posedge clk); #1;
    end
  endtask

  // lw $5 ; add $9,$1,$5 (stall once, then MEM fwd B) ; use $9 (EX fwd B)
  task automatic test_load_use;
    stim_t t[$];
    exp_t  e;
    idle(2);
    t.push_back(mk(1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 1, 0, 1, NONE, NONE));
    t.push_back(mk(1, 5'd1, 5'd5, 1, 1, 5'd9, 1, 0, 0, 1, STALL, STALL));
    t.push_back(mk(1, 5'd1, 5'd5, 1, 1, 5'd9, 1, 0, 0, 1, MFB, MFB));
    t.push_back(mk(1, 5'd0, 5'd9, 0, 1, 5'd0, 0, 0, 0, 1, EFB, EFB));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (out1 !== e.e1) begin errors++; $display("FAIL load_use[%0d] dut1: got %b expected %b", i, out1, e.e1); end
      checks++;
      if (out2 !== e.e2) begin errors++; $display("FAIL load_use[%0d] dut2: got %b expected %b", i, out2, e.e2); end
      @(posedge clk); #1;
    end
  endtask

  // Load-use hazard with dmem not ready for 3 cycles: everything holds.
  task automatic test_freeze;
    stim_t t[$];
    exp_t  e;
    idle(2);
    t.push_back(mk(1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 1, 0, 1, NONE, NONE));
    for (int k = 0; k < 3; k++)
      t.push_back(mk(1, 5'd5, 5'd0, 1, 0, 5'd2, 1, 0, 0, 0, FRZ, FRZ));
    t.push_back(mk(1, 5'd5, 5'd0, 1, 0, 5'd2, 1, 0, 0, 1, STALL, STALL));
    t.push_back(mk(1, 5'd5, 5'd0, 1, 0, 5'd2, 1, 0, 0, 1, MFA, MFA));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (out1 !== e.e1) begin errors++; $display("FAIL freeze[%0d] dut1: got %b expected %b", i, out1, e.e1); end
      checks++;
      if (out2 !== e.e2) begin errors++; $display("FAIL freeze[%0d] dut2: got %b expected %b", i, out2, e.e2); end
      @(posedge clk); #1;
    end
  endtask

  // jr ; lw $4 ; use $4 (load-use during FLUSH: flush wins) ; use $4.
  // dut1 flushes one cycle, dut2 two cycles.
  task automatic test_jr_flush;
    stim_t t[$];
    exp_t  e;
    idle(2);
    t.push_back(mk(1, 5'd31, 5'd0, 1, 0, 5'd0, 0, 0, 1, 1, NONE, NONE));
    t.push_back(mk(1, 5'd0, 5'd0, 0, 0, 5'd4, 1, 1, 0, 1, NONE, NONE));
    t.push_back(mk(1, 5'd4, 5'd0, 1, 0, 5'd6, 1, 0, 0, 1, FLSH, FLSH));
    t.push_back(mk(1, 5'd4, 5'd0, 1, 0, 5'd0, 0, 0, 0, 1, MFA, FLSH));
    t.push_back(mk(1, 5'd4, 5'd0, 1, 0, 5'd0, 0, 0, 0, 1, NONE, NONE));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (out1 !== e.e1) begin errors++; $display("FAIL jr_flush[%0d] dut1: got %b expected %b", i, out1, e.e1); end
      checks++;
      if (out2 !== e.e2) begin errors++; $display("FAIL jr_flush[%0d] dut2: got %b expected %b", i, out2, e.e2); end
      @(posedge clk); #1;
    end
  endtask

  // Reset asserted while flushing clears outputs without waiting for a clock.
  task automatic test_reset_mid_flush;
    stim_t t[$];
    exp_t  e;
    idle(2);
    t.push_back(mk(1, 5'd31, 5'd0, 1, 0, 5'd0, 0, 0, 1, 1, NONE, NONE));
    t.push_back(mk(1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0, 1, NONE, NONE));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (out1 !== e.e1) begin errors++; $display("FAIL rst_flush_pre[%0d] dut1: got %b expected %b", i, out1, e.e1); end
      checks++;
      if (out2 !== e.e2) begin errors++; $display("FAIL rst_flush_pre[%0d] dut2: got %b expected %b", i, out2, e.e2); end
      @(posedge clk); #1;
    end
    apply(mk(1, 5'd3, 5'd0, 1, 0, 5'd0, 0, 0, 0, 1, FLSH, FLSH));
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (out1 !== e.e1) begin errors++; $display("FAIL rst_flush_active dut1: got %b expected %b", out1, e.e1); end
    checks++;
    if (out2 !== e.e2) begin errors++; $display("FAIL rst_flush_active dut2: got %b expected %b", out2, e.e2); end
    #1 rst = 1'b0;
    apply(mk(1, 5'd3, 5'd0, 1, 0, 5'd0, 0, 0, 0, 1, NONE, NONE));
    #1;
    e = sb.pop_front();
    checks++;
    if (out1 !== e.e1) begin errors++; $display("FAIL rst_flush_async dut1: got %b expected %b", out1, e.e1); end
    checks++;
    if (out2 !== e.e2) begin errors++; $display("FAIL rst_flush_async dut2: got %b expected %b", out2, e.e2); end
    @(posedge clk); #1;
    rst = 1'b1;
    apply(mk(1, 5'd3, 5'd0, 1, 0, 5'd0, 0, 0, 0, 1, NONE, NONE));
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (out1 !== e.e1) begin errors++; $display("FAIL rst_flush_after dut1: got %b expected %b", out1, e.e1); end
    checks++;
    if (out2 !== e.e2) begin errors++; $display("FAIL rst_flush_after dut2: got %b expected %b", out2, e.e2); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_zero_reg();
    test_priority();
    test_load_use();
    test_freeze();
    test_jr_flush();
    test_reset_mid_flush();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Pipeline controller for the 5-stage 32-bit MIPS datapath. It shadows destination/control info for the EX and MEM stages and compares it against the ID-stage source registers. It drives the four forwarding-mux selects, stalls the front end on load-use hazards, and flushes wrong-path instructions after jr. It also freezes the whole pipeline while data memory is not ready.

Parameters:
REG_AW, 5, register address width
JR_FLUSH_CYCLES, 1, cycles of flush after a jr enters EX (1..3)
PERF_W, 16, width of performance counters (used only with HAZARD_PERF_EN)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low
id_valid  in  1  ID stage holds a real instruction
id_rs  in  REG_AW  ID source register A
id_rt  in  REG_AW  ID source register B
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt
id_dst  in  REG_AW  destination register (after RegDst select)
id_regwr  in  1  instruction writes register file
id_load  in  1  instruction is a load (MemToReg)
id_is_jr  in  1  instruction is jr
dmem_ready  in  1  data memory can complete this cycle
ex_forward_a  out  1  select ALU result for operand A
mem_forward_a  out  1  select MEM write-back data for operand A
ex_forward_b  out  1  same, operand B
mem_forward_b  out  1  same, operand B
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
bubble_ex  out  1  load NOP controls into ID/EX
flush_id  out  1  load NOP into IF/ID
freeze  out  1  hold all pipeline registers

Behaviour:
- Shadow entries EX and MEM: {valid, dst, regwr, load}. Reset clears all to 0.
- Update on each edge when freeze=0:
  - EX <= ID fields, with valid = id_valid & ~bubble_ex.
  - MEM <= EX.
- When freeze=1, shadow entries, FSM and counter hold.
- Forwarding (combinational, operand A shown; B is identical with rt/id_uses_rt):
  - match_ex = id_uses_rs & EX.valid & EX.regwr & EX.dst==id_rs & id_rs!=0
  - ex_forward_a = match_ex & ~EX.load
  - mem_forward_a = ~match_ex & MEM.valid & MEM.regwr & MEM.dst==id_rs & id_rs!=0
  - EX has priority over MEM. Register $0 never forwards.
- WB needs no forwarding: the register file writes before it is read within a cycle.
- Load-use: lu = id_valid & match_ex & EX.load, evaluated for A or B.
  - Effect: stall_if = stall_id = bubble_ex = 1 for exactly one cycle.
  - Next cycle the load is in MEM, so mem_forward resolves the operand.
- FSM states:
  - RUN: normal operation.
    - jr enters EX (EX.valid & latched is_jr) with freeze=0 → FLUSH, cnt <= JR_FLUSH_CYCLES-1.
  - FLUSH: flush_id = bubble_ex = 1; stall_if = stall_id = 0; forwarding selects forced to 0.
    - cnt==0 & ~freeze → RUN; otherwise decrement cnt.
  - is_jr is carried in the EX shadow entry as an extra bit.
- Priority: freeze > FLUSH > load-use.
  - freeze = ~dmem_ready, asserted combinationally.
  - Under freeze, stall/bubble/flush outputs are 0 (everything holds anyway). Forward selects stay valid.
- A load-use and a jr in EX in the same cycle → FLUSH wins; the ID instruction is squashed.
- Reset values: all outputs 0, FSM=RUN, cnt=0. Reset asserted mid-FLUSH aborts the flush immediately.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds outputs stall_cnt, flush_cnt, freeze_cnt (each PERF_W).
  - Each increments on every edge where lu (not overridden), FLUSH, or freeze respectively is active.
  - Counters saturate at all-ones and reset to 0.
- Undefined: no counter ports or logic; all other behaviour is identical.

Decomposition:
- Package hazard_pkg: REG_AW constant, typedef stage_info_t {valid, dst, regwr, load, is_jr}, enum hz_state_t {RUN, FLUSH}.
- One sub-module: fwd_compare (operand-vs-EX/MEM match logic), instantiated twice for A and B.

Test Plan:
- add $3 in EX; ID reads rs=$3 → ex_forward_a=1, mem_forward_a=0, no stall.
- lw $5 in EX; ID add uses rt=$5 → one cycle stall_if=stall_id=bubble_ex=1; next cycle mem_forward_b=1, ex_forward_b=0.
- Writer of $0 in EX; ID reads rs=$0 → all forward selects 0.
- Same dst $7 in EX and MEM; ID reads $7 → ex_forward_a=1 only.
- jr enters EX with JR_FLUSH_CYCLES=1 → flush_id=bubble_ex=1 for 1 cycle, then RUN. With 2 → 2 cycles.
- dmem_ready=0 for 3 cycles during a load-use stall → freeze=1, shadow state held, stall resumes after. Reset pulse mid-FLUSH → all outputs 0 at once.
